// File: rtl/memory_moc_unit.sv
// Big-endian byte memory answering MFA with a registered MOC LATENCY edges after the request is latched.
// MOC holds while MFA stays high; dropping MFA before completion abandons the access (writes never land).
module memory_moc_unit #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              ReadWrite,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  logic [7:0]        mem [0:DEPTH-1];

  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [31:0]       rd_word;
  logic              access;
  logic              mem_we;

  // Misaligned addresses are silently aligned down; byte offsets wrap within the array.
  always_comb begin
    a0 = addr_q;
    case (size_q)
      2'b00:   a0 = addr_q;
      2'b01:   a0 = (addr_q >> 1) << 1;
      default: a0 = (addr_q >> 2) << 2;
    endcase
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
  end

  always_comb begin
    rd_word = '0;
    case (size_q)
      2'b00:   rd_word = {24'h000000, mem[a0]};
      2'b01:   rd_word = {16'h0000, mem[a0], mem[a1]};
      default: rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // The access fires only on the final WAIT edge, and only if the requester is still asking.
  assign access = (state == S_WAIT) && MFA && (cnt == 4'd0);
  assign mem_we = access && !rw_q && !Reset;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      case (size_q)
        2'b00: mem[a0] <= din_q[7:0];
        2'b01: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        default: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      MOC     <= 1'b0;
      DataOut <= 32'h0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      din_q   <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MFA) begin
            rw_q   <= ReadWrite;
            size_q <= Size;
            addr_q <= Address;
            din_q  <= DataIn;
            cnt    <= 4'(LATENCY - 1);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!MFA) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            if (rw_q) begin
              DataOut <= rd_word;
            end
            MOC   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (!MFA) begin
            MOC   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          MOC   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_moc_unit.sv
// Directed bench: dut2 runs with LATENCY=2, dut3 with LATENCY=3; both share every input except MFA.
module tb_memory_moc_unit;

  logic        clk;
  logic        reset;
  logic        mfa2;
  logic        mfa3;
  logic        rw;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout2;
  logic [31:0] dout3;
  logic        moc2;
  logic        moc3;

  int checks = 0;
  int errors = 0;

  memory_moc_unit #(.LATENCY(2), .ADDR_W(8)) dut2 (
    .Clk(clk), .Reset(reset), .MFA(mfa2), .ReadWrite(rw), .Size(size),
    .Address(addr), .DataIn(din), .DataOut(dout2), .MOC(moc2)
  );

  memory_moc_unit #(.LATENCY(3), .ADDR_W(8)) dut3 (
    .Clk(clk), .Reset(reset), .MFA(mfa3), .ReadWrite(rw), .Size(size),
    .Address(addr), .DataIn(din), .DataOut(dout3), .MOC(moc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access on dut2; cyc is the number of edges after the latching edge until MOC (-1 on timeout).
  task automatic run2(input logic r, input logic [1:0] s, input logic [7:0] a,
                      input logic [31:0] d, output int cyc);
    rw = r; size = s; addr = a; din = d; mfa2 = 1'b1;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (moc2 === 1'b1) begin
        cyc = i;
        break;
      end
    end
    mfa2 = 1'b0;
    tick();
  endtask

  task automatic run3(input logic r, input logic [1:0] s, input logic [7:0] a,
                      input logic [31:0] d, output int cyc);
    rw = r; size = s; addr = a; din = d; mfa3 = 1'b1;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (moc3 === 1'b1) begin
        cyc = i;
        break;
      end
    end
    mfa3 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; mfa2 = 1'b0; mfa3 = 1'b0; rw = 1'b1; size = 2'b10; addr = 8'h00; din = 32'h0;
    tick();
    tick();
    for (int i = 0; i < 256; i++) begin
      dut2.mem[i] = 8'h00;
      dut3.mem[i] = 8'h00;
    end
    reset = 1'b0;
    tick();
    checks++; if (moc2 !== 1'b0) begin errors++; $display("FAIL reset_moc2 got %b want 0", moc2); end
    checks++; if (dout2 !== 32'h0) begin errors++; $display("FAIL reset_dout2 got %h want 00000000", dout2); end
    checks++; if (moc3 !== 1'b0) begin errors++; $display("FAIL reset_moc3 got %b want 0", moc3); end
  endtask

  task automatic test_word_read();
    dut2.mem[8'h10] = 8'hE5; dut2.mem[8'h11] = 8'h9F;
    dut2.mem[8'h12] = 8'h10; dut2.mem[8'h13] = 8'h04;
    rw = 1'b1; size = 2'b10; addr = 8'h12; mfa2 = 1'b1;
    tick();
    addr = 8'h00; size = 2'b00;
    checks++; if (moc2 !== 1'b0) begin errors++; $display("FAIL wr_moc_e0 got %b want 0", moc2); end
    tick();
    checks++; if (moc2 !== 1'b0) begin errors++; $display("FAIL wr_moc_e1 got %b want 0", moc2); end
    tick();
    checks++; if (moc2 !== 1'b1) begin errors++; $display("FAIL wr_moc_e2 got %b want 1", moc2); end
    checks++; if (dout2 !== 32'hE59F1004) begin errors++; $display("FAIL wr_data got %h want e59f1004", dout2); end
    mfa2 = 1'b0;
    tick();
    checks++; if (moc2 !== 1'b0) begin errors++; $display("FAIL wr_moc_fall got %b want 0", moc2); end
    tick();
    checks++; if (dout2 !== 32'hE59F1004) begin errors++; $display("FAIL wr_data_hold got %h want e59f1004", dout2); end
  endtask

  task automatic test_byte_write();
    int cyc;
    dut2.mem[8'h20] = 8'h00; dut2.mem[8'h21] = 8'h00;
    dut2.mem[8'h22] = 8'h00; dut2.mem[8'h23] = 8'h00;
    run2(1'b0, 2'b00, 8'h21, 32'h5A5A5AAB, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL bw_latency got %0d want 2", cyc); end
    checks++; if (dut2.mem[8'h21] !== 8'hAB) begin errors++; $display("FAIL bw_mem21 got %h want ab", dut2.mem[8'h21]); end
    checks++; if ({dut2.mem[8'h20], dut2.mem[8'h22], dut2.mem[8'h23]} !== 24'h000000) begin
      errors++; $display("FAIL bw_neighbours got %h want 000000", {dut2.mem[8'h20], dut2.mem[8'h22], dut2.mem[8'h23]});
    end
    checks++; if (dout2 !== 32'hE59F1004) begin errors++; $display("FAIL bw_dout_hold got %h want e59f1004", dout2); end
    run2(1'b1, 2'b10, 8'h20, 32'h0, cyc);
    checks++; if (dout2 !== 32'h00AB0000) begin errors++; $display("FAIL bw_readback got %h want 00ab0000", dout2); end
  endtask

  task automatic test_halfword();
    int cyc;
    dut2.mem[8'h30] = 8'h11; dut2.mem[8'h31] = 8'h22;
    dut2.mem[8'h32] = 8'h33; dut2.mem[8'h33] = 8'h44;
    run2(1'b0, 2'b01, 8'h31, 32'hDEADBEEF, cyc);
    checks++; if ({dut2.mem[8'h30], dut2.mem[8'h31]} !== 16'hBEEF) begin
      errors++; $display("FAIL hw_mem got %h want beef", {dut2.mem[8'h30], dut2.mem[8'h31]});
    end
    checks++; if ({dut2.mem[8'h32], dut2.mem[8'h33]} !== 16'h3344) begin
      errors++; $display("FAIL hw_untouched got %h want 3344", {dut2.mem[8'h32], dut2.mem[8'h33]});
    end
    run2(1'b1, 2'b01, 8'h30, 32'h0, cyc);
    checks++; if (dout2 !== 32'h0000BEEF) begin errors++; $display("FAIL hw_read got %h want 0000beef", dout2); end
    run2(1'b1, 2'b00, 8'h31, 32'h0, cyc);
    checks++; if (dout2 !== 32'h000000EF) begin errors++; $display("FAIL byte_read got %h want 000000ef", dout2); end
    run2(1'b1, 2'b11, 8'h33, 32'h0, cyc);
    checks++; if (dout2 !== 32'hBEEF3344) begin errors++; $display("FAIL size11_read got %h want beef3344", dout2); end
  endtask

  task automatic test_abort();
    int highs;
    int cyc;
    dut3.mem[8'h40] = 8'hA1; dut3.mem[8'h41] = 8'hA2;
    dut3.mem[8'h42] = 8'hA3; dut3.mem[8'h43] = 8'hA4;
    rw = 1'b0; size = 2'b10; addr = 8'h40; din = 32'h12345678; mfa3 = 1'b1;
    highs = 0;
    tick();
    if (moc3) highs++;
    tick();
    if (moc3) highs++;
    mfa3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (moc3) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL abort_mfa_moc got %0d high cycles want 0", highs); end
    checks++; if ({dut3.mem[8'h40], dut3.mem[8'h41], dut3.mem[8'h42], dut3.mem[8'h43]} !== 32'hA1A2A3A4) begin
      errors++; $display("FAIL abort_mfa_mem got %h want a1a2a3a4",
                        {dut3.mem[8'h40], dut3.mem[8'h41], dut3.mem[8'h42], dut3.mem[8'h43]});
    end
    mfa3 = 1'b1;
    highs = 0;
    tick();
    tick();
    if (moc3) highs++;
    reset = 1'b1; mfa3 = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (moc3) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL abort_rst_moc got %0d high cycles want 0", highs); end
    checks++; if ({dut3.mem[8'h40], dut3.mem[8'h41], dut3.mem[8'h42], dut3.mem[8'h43]} !== 32'hA1A2A3A4) begin
      errors++; $display("FAIL abort_rst_mem got %h want a1a2a3a4",
                        {dut3.mem[8'h40], dut3.mem[8'h41], dut3.mem[8'h42], dut3.mem[8'h43]});
    end
    run3(1'b1, 2'b10, 8'h41, 32'h0, cyc);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL lat3_latency got %0d want 3", cyc); end
    checks++; if (dout3 !== 32'hA1A2A3A4) begin errors++; $display("FAIL lat3_read got %h want a1a2a3a4", dout3); end
  endtask

  task automatic test_back_to_back();
    int lows;
    int cyc;
    rw = 1'b1; size = 2'b10; addr = 8'h10; mfa2 = 1'b1;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (moc2 === 1'b1) begin
        cyc = i;
        break;
      end
    end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL b2b_first_latency got %0d want 2", cyc); end
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (moc2 !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL b2b_hold got %0d low cycles want 0", lows); end
    mfa2 = 1'b0;
    tick();
    checks++; if (moc2 !== 1'b0) begin errors++; $display("FAIL b2b_fall got %b want 0", moc2); end
    addr = 8'h30;
    mfa2 = 1'b1;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (moc2 === 1'b1) begin
        cyc = i;
        break;
      end
    end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL b2b_second_latency got %0d want 2", cyc); end
    checks++; if (dout2 !== 32'hBEEF3344) begin errors++; $display("FAIL b2b_second_data got %h want beef3344", dout2); end
    mfa2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_done();
    int cyc;
    rw = 1'b1; size = 2'b10; addr = 8'h10; mfa2 = 1'b1;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (moc2 === 1'b1) begin
        cyc = i;
        break;
      end
    end
    checks++; if (dout2 !== 32'hE59F1004) begin errors++; $display("FAIL rd_pre_data got %h want e59f1004", dout2); end
    reset = 1'b1;
    tick();
    checks++; if (moc2 !== 1'b0) begin errors++; $display("FAIL rd_moc got %b want 0", moc2); end
    checks++; if (dout2 !== 32'h0) begin errors++; $display("FAIL rd_dout got %h want 00000000", dout2); end
    checks++; if ({dut2.mem[8'h10], dut2.mem[8'h11], dut2.mem[8'h12], dut2.mem[8'h13]} !== 32'hE59F1004) begin
      errors++; $display("FAIL rd_mem_kept got %h want e59f1004",
                        {dut2.mem[8'h10], dut2.mem[8'h11], dut2.mem[8'h12], dut2.mem[8'h13]});
    end
    mfa2 = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_halfword();
    test_abort();
    test_back_to_back();
    test_reset_in_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
